// File: rtl/debug_module_if.sv
// debug_module_if: DMI, hart-control and abstract-access signals of the Debug Module.
interface debug_module_if;
    logic        dmi_start;
    logic        dmi_finish;
    logic [1:0]  dmi_op;
    logic [6:0]  dmi_address;
    logic [31:0] dmi_data_i;
    logic [31:0] dmi_data_o;
    logic        hart_halt_req;
    logic        hart_resume_req;
    logic        hart_halted;
    logic        hart_resume_ack;
    logic        ndmreset;
    logic        ar_req;
    logic        ar_write;
    logic [4:0]  ar_regno;
    logic [31:0] ar_wdata;
    logic [31:0] ar_rdata;
    logic        ar_ack;

    modport slave (
        input  dmi_start, dmi_op, dmi_address, dmi_data_i, hart_halted, hart_resume_ack, ar_rdata, ar_ack,
        output dmi_finish, dmi_data_o, hart_halt_req, hart_resume_req, ndmreset, ar_req, ar_write, ar_regno, ar_wdata
    );

    modport master (
        output dmi_start, dmi_op, dmi_address, dmi_data_i, hart_halted, hart_resume_ack, ar_rdata, ar_ack,
        input  dmi_finish, dmi_data_o, hart_halt_req, hart_resume_req, ndmreset, ar_req, ar_write, ar_regno, ar_wdata
    );
endinterface

// File: rtl/debug_module.sv
// debug_module: single-hart RISC-V Debug Module turning DMI accesses into halt/resume and abstract GPR access.
// Define DM_AR_TIMEOUT_EN to add a watchdog that aborts abstract accesses after TIMEOUT_CYCLES.
module debug_module #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic           clk,
    input logic           rst_n,
    debug_module_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DECODE, RESP} dmi_state_t;
    typedef enum logic {AIDLE, AREQ} ar_state_t;

    dmi_state_t  r_dmi_state, w_dmi_next;
    ar_state_t   r_ar_state, w_ar_next;
    logic [1:0]  r_op;
    logic [6:0]  r_addr;
    logic [31:0] r_wdata, r_rdata, r_data0, r_ar_wdata, w_rmux, w_data0_next;
    logic [2:0]  r_cmderr, w_cmderr_next;
    logic [4:0]  r_ar_regno;
    logic        r_haltreq, r_ndmreset, r_dmactive, r_resume_req, r_resumeack, r_ar_write;
    logic        w_dec, w_wr, w_wr_dmc, w_wr_d0, w_wr_acs, w_wr_cmd;
    logic        w_active, w_busy, w_ack, w_bad, w_launch, w_resume_set, w_tmo;

    assign w_dec        = r_dmi_state == DECODE;
    assign w_wr         = w_dec && r_op == 2'd2;
    assign w_wr_dmc     = w_wr && r_addr == 7'h10;
    assign w_wr_d0      = w_wr && r_addr == 7'h04;
    assign w_wr_acs     = w_wr && r_addr == 7'h16;
    assign w_wr_cmd     = w_wr && r_addr == 7'h17;
    // dmactive written in this cycle takes effect together with the other dmcontrol bits
    assign w_active     = w_wr_dmc ? r_wdata[0] : r_dmactive;
    assign w_busy       = r_ar_state == AREQ;
    assign w_ack        = w_busy && bus.ar_ack;
    assign w_bad        = r_wdata[31:24] != 8'd0 || r_wdata[22:20] != 3'd2 || (r_wdata[17] && r_wdata[15:5] != 11'h080);
    assign w_launch     = w_wr_cmd && r_cmderr == 3'd0 && !w_busy && !w_bad && bus.hart_halted && r_wdata[17];
    assign w_resume_set = w_wr_dmc && r_wdata[30] && !r_wdata[31];

`ifdef DM_AR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_cnt <= '0;
        else r_cnt <= (w_busy && !w_ack && w_active) ? r_cnt + 1'b1 : '0;
    assign w_tmo = w_busy && !bus.ar_ack && r_cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    // no watchdog: the expression is constant false
    assign w_tmo = TIMEOUT_CYCLES < 0;
`endif

    always_comb begin
        w_rmux = 32'h0;
        case (r_addr)
            7'h04:   w_rmux = r_data0;
            7'h10:   w_rmux = {r_haltreq, 29'h0, r_ndmreset, r_dmactive};
            7'h11:   w_rmux = {14'h0, {2{r_resumeack}}, 4'h0, {2{!bus.hart_halted}}, {2{bus.hart_halted}}, 8'h82};
            7'h16:   w_rmux = {19'h0, w_busy, 1'b0, r_cmderr, 8'h01};
            default: w_rmux = 32'h0;
        endcase
    end

    always_comb begin
        w_cmderr_next = r_cmderr;
        if (w_wr_acs) w_cmderr_next = r_cmderr & ~r_wdata[10:8];
        if (w_wr_d0 && w_busy && r_cmderr == 3'd0) w_cmderr_next = 3'd1;
        if (w_wr_cmd && r_cmderr == 3'd0)
            w_cmderr_next = w_busy ? 3'd1 : w_bad ? 3'd2 : !bus.hart_halted ? 3'd4 : 3'd0;
        if (w_tmo) w_cmderr_next = 3'd3;
    end

    // a coinciding ar_ack capture wins over a DMI data0 write, which busy drops anyway
    assign w_data0_next = (w_ack && !r_ar_write) ? bus.ar_rdata : (w_wr_d0 && !w_busy) ? r_wdata : r_data0;

    always_comb begin
        w_dmi_next = IDLE;
        case (r_dmi_state)
            IDLE:    w_dmi_next = bus.dmi_start ? DECODE : IDLE;
            DECODE:  w_dmi_next = RESP;
            default: w_dmi_next = IDLE;
        endcase
        w_ar_next = w_busy ? ((w_ack || w_tmo) ? AIDLE : AREQ) : (w_launch ? AREQ : AIDLE);
        if (!w_active) w_ar_next = AIDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_dmi_state <= IDLE;
            r_ar_state  <= AIDLE;
        end else begin
            r_dmi_state <= w_dmi_next;
            r_ar_state  <= w_ar_next;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_op    <= 2'd0;
            r_addr  <= 7'd0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
        end else begin
            if (r_dmi_state == IDLE && bus.dmi_start) begin
                r_op    <= bus.dmi_op;
                r_addr  <= bus.dmi_address;
                r_wdata <= bus.dmi_data_i;
            end
            if (w_dec) r_rdata <= r_op == 2'd1 ? w_rmux : 32'h0;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_dmactive   <= 1'b0;
            r_haltreq    <= 1'b0;
            r_ndmreset   <= 1'b0;
            r_resume_req <= 1'b0;
            r_resumeack  <= 1'b0;
            r_data0      <= 32'h0;
            r_cmderr     <= 3'd0;
            r_ar_write   <= 1'b0;
            r_ar_regno   <= 5'd0;
            r_ar_wdata   <= 32'h0;
        end else if (!w_active) begin
            r_dmactive   <= 1'b0;
            r_haltreq    <= 1'b0;
            r_ndmreset   <= 1'b0;
            r_resume_req <= 1'b0;
            r_resumeack  <= 1'b0;
            r_data0      <= 32'h0;
            r_cmderr     <= 3'd0;
            r_ar_write   <= 1'b0;
            r_ar_regno   <= 5'd0;
            r_ar_wdata   <= 32'h0;
        end else begin
            r_dmactive <= 1'b1;
            if (w_wr_dmc) begin
                r_haltreq  <= r_wdata[31];
                r_ndmreset <= r_wdata[1];
            end
            r_resume_req <= w_resume_set ? 1'b1 : bus.hart_resume_ack ? 1'b0 : r_resume_req;
            r_resumeack  <= w_resume_set ? 1'b0 : bus.hart_resume_ack ? 1'b1 : r_resumeack;
            r_data0      <= w_data0_next;
            r_cmderr     <= w_cmderr_next;
            if (w_launch) begin
                r_ar_write <= r_wdata[16];
                r_ar_regno <= r_wdata[4:0];
                r_ar_wdata <= r_data0;
            end
        end

    assign bus.dmi_finish      = r_dmi_state == RESP;
    assign bus.dmi_data_o      = r_rdata;
    assign bus.hart_halt_req   = r_haltreq;
    assign bus.hart_resume_req = r_resume_req;
    assign bus.ndmreset        = r_ndmreset;
    assign bus.ar_req          = w_busy;
    assign bus.ar_write        = r_ar_write;
    assign bus.ar_regno        = r_ar_regno;
    assign bus.ar_wdata        = r_ar_wdata;
endmodule

// File: tb/tb_debug_module.sv
// tb_debug_module: directed and randomized DMI/hart/abstract traffic checked against a transaction-level DM model.
module tb_debug_module;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    debug_module_if bus ();
    debug_module #(.TIMEOUT_CYCLES(256)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] m_data0, m_ar_wdata;
    logic [2:0]  m_cmderr;
    logic [4:0]  m_regno;
    logic        m_active, m_halt, m_ndm, m_rreq, m_rack, m_busy, m_arw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_data0 = 32'h0; m_ar_wdata = 32'h0; m_cmderr = 3'd0; m_regno = 5'd0;
        m_active = 1'b0; m_halt = 1'b0; m_ndm = 1'b0; m_rreq = 1'b0; m_rack = 1'b0; m_busy = 1'b0; m_arw = 1'b0;
    endtask

    function automatic logic [31:0] exp_read(input logic [6:0] a);
        case (a)
            7'h04:   return m_data0;
            7'h10:   return (m_halt ? 32'h8000_0000 : 32'h0) | (m_ndm ? 32'h2 : 32'h0) | (m_active ? 32'h1 : 32'h0);
            7'h11:   return 32'h82 | (bus.hart_halted ? 32'h300 : 32'hC00) | (m_rack ? 32'h30000 : 32'h0);
            7'h16:   return 32'h1 | (32'(m_cmderr) << 8) | (m_busy ? 32'h1000 : 32'h0);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_ack(input logic [31:0] rd);
        if (m_active && m_busy) begin
            m_busy = 1'b0;
            if (!m_arw) m_data0 = rd;
        end
    endtask

    task automatic model_rack();
        if (m_active) begin m_rreq = 1'b0; m_rack = 1'b1; end
    endtask

    task automatic model_write(input logic [6:0] a, input logic [31:0] d);
        logic [15:0] rg;
        rg = d[15:0];
        if (a == 7'h10) begin
            if (!d[0]) model_reset();
            else begin
                m_active = 1'b1; m_halt = d[31]; m_ndm = d[1];
                if (d[30] && !d[31]) begin m_rreq = 1'b1; m_rack = 1'b0; end
            end
        end else if (m_active) begin
            if (a == 7'h04) begin
                if (!m_busy) m_data0 = d;
                else if (m_cmderr == 3'd0) m_cmderr = 3'd1;
            end else if (a == 7'h16) m_cmderr = m_cmderr & ~d[10:8];
            else if (a == 7'h17 && m_cmderr == 3'd0) begin
                if (m_busy) m_cmderr = 3'd1;
                else if (d[31:24] != 8'd0 || d[22:20] != 3'd2 || (d[17] && (rg < 16'h1000 || rg > 16'h101F))) m_cmderr = 3'd2;
                else if (!bus.hart_halted) m_cmderr = 3'd4;
                else if (d[17]) begin
                    m_busy = 1'b1; m_arw = d[16]; m_regno = 5'(rg - 16'h1000); m_ar_wdata = m_data0;
                end
            end
        end
    endtask

    task automatic chk_outs();
        chk("ar_req", 32'(bus.ar_req), 32'(m_busy));
        if (m_busy) begin
            chk("ar_write", 32'(bus.ar_write), 32'(m_arw));
            chk("ar_regno", 32'(bus.ar_regno), 32'(m_regno));
            chk("ar_wdata", bus.ar_wdata, m_ar_wdata);
        end
        chk("halt_req", 32'(bus.hart_halt_req), 32'(m_halt));
        chk("resume_req", 32'(bus.hart_resume_req), 32'(m_rreq));
        chk("ndmreset", 32'(bus.ndmreset), 32'(m_ndm));
    endtask

    task automatic dmi(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d,
                       input logic co_ack, input logic [31:0] co_rdata, input logic co_rack);
        logic [31:0] exp;
        exp = exp_read(a);
        @(negedge clk);
        bus.dmi_start = 1'b1; bus.dmi_op = op; bus.dmi_address = a; bus.dmi_data_i = d;
        @(negedge clk);
        bus.dmi_start = 1'b0;
        chk("fin_early", 32'(bus.dmi_finish), 32'h0);
        bus.ar_ack = co_ack; bus.ar_rdata = co_rdata; bus.hart_resume_ack = co_rack;
        @(negedge clk);
        bus.ar_ack = 1'b0; bus.hart_resume_ack = 1'b0;
        chk("fin", 32'(bus.dmi_finish), 32'h1);
        if (op == 2'd1) chk($sformatf("rd_%02h", a), bus.dmi_data_o, exp);
        if (co_rack) model_rack();
        if (op == 2'd2) model_write(a, d);
        if (co_ack) model_ack(co_rdata);
        @(negedge clk);
        chk("fin_pulse", 32'(bus.dmi_finish), 32'h0);
        chk_outs();
    endtask

    task automatic rd(input logic [6:0] a);
        dmi(2'd1, a, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        dmi(2'd2, a, d, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic ack_pulse(input logic [31:0] rdv);
        @(negedge clk);
        bus.ar_ack = 1'b1; bus.ar_rdata = rdv;
        @(negedge clk);
        bus.ar_ack = 1'b0;
        model_ack(rdv);
        chk_outs();
    endtask

    task automatic rack_pulse();
        @(negedge clk);
        bus.hart_resume_ack = 1'b1;
        @(negedge clk);
        bus.hart_resume_ack = 1'b0;
        model_rack();
        chk_outs();
    endtask

    logic [31:0] cmd_tab [6];
    logic [6:0]  addr_tab [6];
    logic [31:0] cmd;
    logic [15:0] rg;
    int unsigned k;
    int          busy_n;
    int          cyc;

    initial begin
        bus.dmi_start = 1'b0; bus.dmi_op = 2'd0; bus.dmi_address = 7'd0; bus.dmi_data_i = 32'h0;
        bus.hart_halted = 1'b0; bus.hart_resume_ack = 1'b0; bus.ar_rdata = 32'h0; bus.ar_ack = 1'b0;
        cmd_tab[0] = 32'h0022_0000; cmd_tab[1] = 32'h0023_0000; cmd_tab[2] = 32'h0020_0000;
        cmd_tab[3] = 32'h0032_0000; cmd_tab[4] = 32'h0122_0000; cmd_tab[5] = 32'h0002_0000;
        addr_tab[0] = 7'h04; addr_tab[1] = 7'h10; addr_tab[2] = 7'h11;
        addr_tab[3] = 7'h16; addr_tab[4] = 7'h17; addr_tab[5] = 7'h05;
        model_reset();
        busy_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_data_o", bus.dmi_data_o, 32'h0);
        chk("rst_ar_wdata", bus.ar_wdata, 32'h0);
        chk("rst_ctl", 32'({bus.dmi_finish, bus.hart_halt_req, bus.hart_resume_req, bus.ndmreset,
                            bus.ar_req, bus.ar_write, bus.ar_regno}), 32'h0);
        rst_n = 1'b1;
        rd(7'h11);
        rd(7'h10);
        wr(7'h10, 32'h8000_0001);
        bus.hart_halted = 1'b1;
        rd(7'h11);
        wr(7'h04, 32'hDEAD_BEEF);
        wr(7'h17, 32'h0023_1005);
        rd(7'h16);
        wr(7'h17, 32'h0022_1003);
        rd(7'h16);
        wr(7'h16, 32'h0000_0700);
        ack_pulse(32'h5555_AAAA);
        rd(7'h04);
        wr(7'h17, 32'h0022_1003);
        ack_pulse(32'h1234_5678);
        rd(7'h04);
        rd(7'h16);
        wr(7'h17, 32'h0022_101F);
        ack_pulse(32'h0000_001F);
        wr(7'h17, 32'h0022_1020);
        rd(7'h16);
        wr(7'h16, 32'h0000_0700);
        wr(7'h17, 32'h0022_0FFF);
        rd(7'h16);
        wr(7'h16, 32'h0000_0700);
        bus.hart_halted = 1'b0;
        wr(7'h17, 32'h0022_1003);
        rd(7'h16);
        wr(7'h16, 32'h0000_0700);
        rd(7'h16);
        wr(7'h10, 32'h4000_0001);
        rack_pulse();
        rd(7'h11);
        wr(7'h10, 32'h4000_0001);
        dmi(2'd2, 7'h10, 32'h4000_0001, 1'b0, 32'h0, 1'b1);
        rd(7'h11);
        rack_pulse();
        bus.hart_halted = 1'b1;
        wr(7'h10, 32'h8000_0003);
        wr(7'h17, 32'h0022_1007);
        dmi(2'd2, 7'h04, 32'hAAAA_5555, 1'b1, 32'h0BAD_F00D, 1'b0);
        rd(7'h04);
        rd(7'h16);
        wr(7'h16, 32'h0000_0700);
        for (int i = 0; i < 300; i++) begin
            k  = $urandom_range(0, 9);
            rg = 16'($urandom_range(32'h0FF8, 32'h1028));
            case (k)
                0: wr(7'h04, $urandom);
                1: begin
                    cmd = cmd_tab[$urandom_range(0, 5)] | {16'h0, rg};
                    wr(7'h17, cmd);
                end
                2, 3: rd(addr_tab[$urandom_range(0, 5)]);
                4: ack_pulse($urandom);
                5: bus.hart_halted = 1'($urandom_range(0, 1));
                6: wr(7'h10, {1'($urandom), 1'($urandom), 28'h0, 1'($urandom), 1'($urandom_range(0, 7) != 0)});
                7: rack_pulse();
                8: wr(7'h16, $urandom_range(0, 1) != 0 ? 32'h0000_0700 : $urandom);
                default: dmi(2'($urandom), addr_tab[$urandom_range(0, 5)], $urandom, 1'b0, 32'h0, 1'b0);
            endcase
            busy_n = m_busy ? busy_n + 1 : 0;
            if (busy_n > 15) ack_pulse($urandom);
        end
        bus.hart_halted = 1'b1;
        wr(7'h10, 32'h0000_0001);
        wr(7'h16, 32'h0000_0700);
        wr(7'h04, 32'h0000_0000);
        wr(7'h17, 32'h0022_1002);
        wr(7'h10, 32'h0000_0000);
        ack_pulse(32'hFFFF_FFFF);
        wr(7'h10, 32'h0000_0001);
        rd(7'h04);
        rd(7'h16);
`ifdef DM_AR_TIMEOUT_EN
        wr(7'h04, 32'hCAFE_0001);
        wr(7'h17, 32'h0022_1004);
        repeat (200) @(negedge clk);
        chk("tmo_early", 32'(bus.ar_req), 32'h1);
        cyc = 0;
        while (bus.ar_req && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("tmo_expired", 32'(bus.ar_req), 32'h0);
        m_busy = 1'b0;
        m_cmderr = 3'd3;
        rd(7'h16);
        ack_pulse(32'h1111_2222);
        rd(7'h04);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
